// File: rtl/xm_uart_pkg.sv
// Shared definitions for the xm_uart receiver/transmitter pair:
// baud codes, the 16x divisor lookup and the receive FSM encoding.
package xm_uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Divisor for a 16x tick: count 0..div gives div+1 clocks per tick.
  // Codes 5-7 fall back to 9600 baud.
  function automatic logic [15:0] baud_div(input int unsigned clk_freq,
                                           input logic [2:0] code);
    int unsigned baud;
    case (code)
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      default:     baud = 9600;
    endcase
    baud_div = 16'(clk_freq / (baud * 16) - 1);
  endfunction

endpackage

// File: rtl/xm_uart_baud_tick.sv
// 16x oversampling tick generator. The baud code is captured when the
// counter is cleared so a frame keeps a constant rate once it has started.
module xm_uart_baud_tick
  import xm_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic [2:0] i_code,
  output logic       o_tick
);

  logic [2:0]  r_code;
  logic [15:0] r_cnt;
  logic [15:0] w_div;

  assign w_div  = baud_div(CLK_FREQ, r_code);
  assign o_tick = (r_cnt == w_div) && !i_clear;

  // Free-running divisor counter, restarted and re-latched on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_code <= BAUD_9600;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_code <= i_code;
    end else if (r_cnt == w_div) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/xm_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, falling-edge start detection,
// 16x oversampling with a 2-of-3 vote around mid-bit, and a one-clock
// rx_done strobe carrying the byte and the stop-bit error flag.
module xm_uart_rx
  import xm_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  localparam logic [3:0] LAST_SAMPLE = 4'(OVS - 1);

  logic       r_sync1, r_sync2, r_prev;
  logic       w_fall, w_start, w_tick;
  rx_state_t  r_state, w_next;
  logic [3:0] r_sampleCnt;
  logic       r_samp7, r_samp8;
  logic       r_vote, r_voteValid;
  logic [2:0] r_bitCnt;
  logic [7:0] r_shift;
  logic [7:0] r_dataByte;
  logic       r_rxDone, r_frameErr;

  assign w_fall  = r_prev & ~r_sync2;
  assign w_start = (r_state == IDLE) && w_fall;

  xm_uart_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_start),
    .i_code (baud_set),
    .o_tick (w_tick)
  );

  // Bring the asynchronous line into the clock domain and keep one
  // extra copy so a 1->0 transition can be seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rs232_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Count ticks within a bit, capture samples 7 and 8, and vote on 9;
  // the vote result is handed to the FSM one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sampleCnt <= '0;
      r_samp7     <= 1'b1;
      r_samp8     <= 1'b1;
      r_vote      <= 1'b1;
      r_voteValid <= 1'b0;
    end else begin
      r_voteValid <= 1'b0;
      if (w_start) begin
        r_sampleCnt <= '0;
      end else if (r_state != IDLE && w_tick) begin
        r_sampleCnt <= (r_sampleCnt == LAST_SAMPLE) ? 4'd0 : r_sampleCnt + 4'd1;
        case (r_sampleCnt)
          4'd7: r_samp7 <= r_sync2;
          4'd8: r_samp8 <= r_sync2;
          4'd9: begin
            r_vote      <= (r_samp7 & r_samp8) | (r_samp7 & r_sync2) | (r_samp8 & r_sync2);
            r_voteValid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: advance only on a fresh bit vote; a high start
  // vote is treated as a glitch and drops back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_fall) w_next = START;
      START: if (r_voteValid) w_next = r_vote ? IDLE : DATA;
      DATA:  if (r_voteValid && r_bitCnt == 3'd7) w_next = STOP;
      STOP:  if (r_voteValid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Assemble the byte LSB first and publish it with the stop-bit status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_dataByte <= '0;
      r_frameErr <= 1'b0;
      r_rxDone   <= 1'b0;
    end else begin
      r_rxDone <= 1'b0;
      case (r_state)
        START: if (r_voteValid) r_bitCnt <= '0;
        DATA: if (r_voteValid) begin
          r_shift[r_bitCnt] <= r_vote;
          r_bitCnt          <= r_bitCnt + 3'd1;
        end
        STOP: if (r_voteValid) begin
          r_dataByte <= r_shift;
          r_frameErr <= ~r_vote;
          r_rxDone   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_byte  = r_dataByte;
  assign rx_done    = r_rxDone;
  assign frame_err  = r_frameErr;
  assign uart_state = (r_state != IDLE);

endmodule

// File: tb/tb_xm_uart_rx.sv
// Directed + randomised bench for xm_uart_rx. A serial line model drives
// frames; a monitor collects every rx_done into a queue that is compared
// against the frames the bench itself intended to send.
module tb_xm_uart_rx;

  localparam int BIT4 = 432;
  localparam int BIT0 = 5208;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxLine;
  logic [2:0] baudSet;
  logic [7:0] dataByte;
  logic       rxDone, frameErr, uartState;

  xm_uart_rx #(.CLK_FREQ(50_000_000), .OVS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_set  (baudSet),
    .rs232_rx  (rxLine),
    .data_byte (dataByte),
    .rx_done   (rxDone),
    .frame_err (frameErr),
    .uart_state(uartState)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int doneCyc = 0;
  int startCyc = 0;
  int widthErr = 0;
  logic prevDone = 1'b0;
  logic [8:0] rxQ[$];
  logic [8:0] expQ[$];

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every completed frame and flag strobes wider than one clock.
  always @(negedge clk) begin
    if (rxDone === 1'b1) begin
      rxQ.push_back({frameErr, dataByte});
      doneCyc <= cyc;
      if (prevDone) widthErr <= widthErr + 1;
    end
    prevDone <= rxDone;
  end

  // Expected outcome of a frame: the byte as sent, error when stop was 0.
  function automatic logic [8:0] modelFrame(input logic [7:0] b, input logic stopV);
    return {~stopV, b};
  endfunction

  task automatic sendBit(input logic v, input int period, input bit spike);
    for (int c = 0; c < period; c++) begin
      rxLine = (spike && c == period / 2) ? ~v : v;
      @(posedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int period, input logic stopV,
                               input bit spike, input bit fullStop);
    expQ.push_back(modelFrame(b, stopV));
    startCyc = cyc;
    sendBit(1'b0, period, 1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i], period, spike);
    if (fullStop) sendBit(stopV, period, 1'b0);
    else rxLine = stopV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expV);
    checks++;
    assert (obs === expV) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expV);
    end
  endtask

  task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic expectFrame(input string tag, input int budget);
    logic [8:0] expV, gotV;
    int got;
    for (int i = 0; i < budget && rxQ.size() == 0; i++) @(posedge clk);
    got = (rxQ.size() > 0) ? 1 : 0;
    checkOutput({tag, " received"}, 32'(got), 32'd1);
    expV = (expQ.size() > 0) ? expQ.pop_front() : 9'h000;
    if (got == 1) begin
      gotV = rxQ.pop_front();
      checkOutput({tag, " data"}, 32'(gotV[7:0]), 32'(expV[7:0]));
      checkOutput({tag, " frame_err"}, 32'(gotV[8]), 32'(expV[8]));
    end
  endtask

  initial begin
    logic [7:0] rnd;
    logic [7:0] partial;

    rst = 1'b1;
    rxLine = 1'b1;
    baudSet = 3'd4;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset data_byte", 32'(dataByte), 32'd0);
    checkOutput("reset rx_done", 32'(rxDone), 32'd0);
    checkOutput("reset frame_err", 32'(frameErr), 32'd0);
    checkOutput("reset uart_state", 32'(uartState), 32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);

    $display("[TB] two frames at 115200");
    applyStimulus(8'hAA, BIT4, 1'b1, 1'b0, 1'b0);
    expectFrame("0xAA", 1000);
    checkRange("latency 115200", doneCyc - startCyc, 4018, 4234);
    repeat (50) @(posedge clk);
    @(negedge clk);
    checkOutput("uart_state between frames", 32'(uartState), 32'd0);
    applyStimulus(8'h55, BIT4, 1'b1, 1'b0, 1'b0);
    expectFrame("0x55", 1000);

    $display("[TB] 9600 baud with a 5208-clock sender");
    baudSet = 3'd0;
    repeat (10) @(posedge clk);
    applyStimulus(8'h3C, BIT0, 1'b1, 1'b0, 1'b0);
    expectFrame("0x3C", 8000);
    checkRange("latency 9600", doneCyc - startCyc, 48360, 50960);
    baudSet = 3'd4;
    repeat (50) @(posedge clk);

    $display("[TB] start-bit glitch");
    rxLine = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch uart_state high", 32'(uartState), 32'd1);
    repeat (50) @(posedge clk);
    rxLine = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch uart_state low", 32'(uartState), 32'd0);
    checkOutput("glitch no rx_done", 32'(rxQ.size()), 32'd0);
    repeat (20) @(posedge clk);
    fork
      applyStimulus(8'h81, BIT4, 1'b1, 1'b0, 1'b0);
      begin
        repeat (1500) @(posedge clk);
        baudSet = 3'd0;
      end
    join
    expectFrame("0x81 baud change ignored", 1000);
    baudSet = 3'd4;
    repeat (50) @(posedge clk);

    $display("[TB] frame error");
    applyStimulus(8'hF0, BIT4, 1'b0, 1'b0, 1'b1);
    rxLine = 1'b1;
    expectFrame("0xF0 bad stop", 1000);
    repeat (100) @(posedge clk);
    applyStimulus(8'h0F, BIT4, 1'b1, 1'b0, 1'b0);
    expectFrame("0x0F clean", 1000);
    repeat (100) @(posedge clk);

    $display("[TB] reset in the middle of a frame");
    partial = 8'h6B;
    sendBit(1'b0, BIT4, 1'b0);
    for (int i = 0; i < 3; i++) sendBit(partial[i], BIT4, 1'b0);
    rxLine = partial[3];
    repeat (200) @(posedge clk);
    @(negedge clk);
    checkOutput("pre-reset uart_state", 32'(uartState), 32'd1);
    checkOutput("pre-reset data_byte", 32'(dataByte), 32'h0F);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid-frame reset data_byte", 32'(dataByte), 32'd0);
    checkOutput("mid-frame reset rx_done", 32'(rxDone), 32'd0);
    checkOutput("mid-frame reset frame_err", 32'(frameErr), 32'd0);
    checkOutput("mid-frame reset uart_state", 32'(uartState), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rxLine = 1'b1;
    repeat (100) @(posedge clk);
    checkOutput("aborted frame no rx_done", 32'(rxQ.size()), 32'd0);
    applyStimulus(8'h99, BIT4, 1'b1, 1'b0, 1'b0);
    expectFrame("0x99 after reset", 1000);
    repeat (50) @(posedge clk);

    $display("[TB] noise and timing");
    applyStimulus(8'h5A, BIT4, 1'b1, 1'b1, 1'b0);
    expectFrame("0x5A spikes", 1000);
    repeat (50) @(posedge clk);
    applyStimulus(8'hC3, 416, 1'b1, 1'b0, 1'b0);
    expectFrame("0xC3 fast sender", 1000);
    repeat (50) @(posedge clk);

    $display("[TB] back-to-back frames");
    rnd = 8'($urandom_range(0, 255));
    applyStimulus(8'h12, BIT4, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h34, BIT4, 1'b1, 1'b0, 1'b1);
    applyStimulus(rnd, BIT4, 1'b1, 1'b0, 1'b0);
    expectFrame("0x12 b2b", 1000);
    expectFrame("0x34 b2b", 1000);
    expectFrame("random b2b", 1000);

    repeat (100) @(posedge clk);
    checkOutput("no extra rx_done", 32'(rxQ.size()), 32'd0);
    checkOutput("rx_done one clock wide", 32'(widthErr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
